// File: rtl/clk_hex_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_hex_io_pkg
// Description : Shared constants for the DE0-CV clock / HEX / LEDR front end.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_hex_io_pkg;

    localparam int                HEXBITS    = 24;
    localparam int                LEDRBITS   = 10;
    localparam int                NUM_DIGITS = 6;
    localparam logic [HEXBITS-1:0] HEXRESET  = 24'hFEDEAD;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/clk_hex_io_seven_seg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_decoder
// Description : Combinational nibble to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decoder
    import clk_hex_io_pkg::*;
(
    input  logic [3:0] in,
    input  logic       off,
    output logic [6:0] out
);

    logic [6:0] w_seg;

    always_comb begin
        w_seg = SEG_BLANK;
        case (in)
            4'h0: w_seg = SEG_0;
            4'h1: w_seg = SEG_1;
            4'h2: w_seg = SEG_2;
            4'h3: w_seg = SEG_3;
            4'h4: w_seg = SEG_4;
            4'h5: w_seg = SEG_5;
            4'h6: w_seg = SEG_6;
            4'h7: w_seg = SEG_7;
            4'h8: w_seg = SEG_8;
            4'h9: w_seg = SEG_9;
            4'hA: w_seg = SEG_A;
            4'hB: w_seg = SEG_B;
            4'hC: w_seg = SEG_C;
            4'hD: w_seg = SEG_D;
            4'hE: w_seg = SEG_E;
            4'hF: w_seg = SEG_F;
            default: w_seg = SEG_BLANK;
        endcase
    end

    assign out = off ? SEG_BLANK : w_seg;

endmodule
`default_nettype wire

// File: rtl/clk_hex_io.sv
`default_nettype none
// ============================================================================
// Module      : clk_hex_io
// Description : DE0-CV front end: behavioural PLL with lock, HEX/LEDR regs.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_hex_io #(
    parameter int                 LOCK_CYCLES = 16,
    parameter int                 CLKDIV      = 1,
    parameter int                 HEXBITS     = clk_hex_io_pkg::HEXBITS,
    parameter int                 LEDRBITS    = clk_hex_io_pkg::LEDRBITS,
    parameter logic [HEXBITS-1:0] HEXRESET    = clk_hex_io_pkg::HEXRESET
) (
    input  logic                clk,
    input  logic                reset,
    output logic                outclk,
    output logic                locked,
    input  logic                wr_hex,
    input  logic                wr_ledr,
    input  logic [31:0]         wdata,
    input  logic [5:0]          hex_off,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic [LEDRBITS-1:0] LEDR
);
    import clk_hex_io_pkg::*;

    localparam int c_LCW = $clog2(LOCK_CYCLES + 1);

    logic [c_LCW-1:0]    r_lock_cnt;
    logic                r_locked;
    logic [HEXBITS-1:0]  r_hex;
    logic [LEDRBITS-1:0] r_ledr;
    logic [6:0]          w_seg [NUM_DIGITS];
    logic                w_unused_wdata;

    // Counter freezes once locked; only reset can drop lock again
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!r_locked) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
            if (r_lock_cnt == c_LCW'(LOCK_CYCLES - 1))
                r_locked <= 1'b1;
        end
    end

    assign locked = r_locked;

    generate
        if (CLKDIV <= 1) begin : g_clk_pass
            assign outclk = clk & ~reset;
        end else begin : g_clk_div
            localparam int c_HALF = CLKDIV / 2;
            localparam int c_DW   = (c_HALF > 1) ? $clog2(c_HALF) : 1;

            logic [c_DW-1:0] r_div;
            logic            r_outclk;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_div    <= '0;
                    r_outclk <= 1'b0;
                end else if (r_div == c_DW'(c_HALF - 1)) begin
                    r_div    <= '0;
                    r_outclk <= ~r_outclk;
                end else begin
                    r_div    <= r_div + 1'b1;
                end
            end

            assign outclk = r_outclk;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex  <= HEXRESET;
            r_ledr <= '0;
        end else begin
            if (wr_hex)
                r_hex <= wdata[HEXBITS-1:0];
            if (wr_ledr)
                r_ledr <= wdata[LEDRBITS-1:0];
        end
    end

    assign LEDR = r_ledr;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            seven_seg_decoder u_dec (
                .in  (r_hex[4*i +: 4]),
                .off (hex_off[i]),
                .out (w_seg[i])
            );
        end
    endgenerate

    assign HEX0 = w_seg[0];
    assign HEX1 = w_seg[1];
    assign HEX2 = w_seg[2];
    assign HEX3 = w_seg[3];
    assign HEX4 = w_seg[4];
    assign HEX5 = w_seg[5];

    assign w_unused_wdata = &{1'b0, wdata[31:HEXBITS]};

endmodule
`default_nettype wire

// File: tb/tb_clk_hex_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_hex_io
// Description : Scoreboard bench for clk_hex_io (CLKDIV=1 and CLKDIV=4 copies).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_hex_io;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_hex = 1'b0;
    logic        wr_ledr = 1'b0;
    logic [31:0] wdata = '0;
    logic [5:0]  hex_off = '0;

    logic        outclk, locked;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0]  LEDR;

    logic        outclk4, locked4;
    logic [6:0]  d4_h0, d4_h1, d4_h2, d4_h3, d4_h4, d4_h5;
    logic [9:0]  d4_ledr;

    clk_hex_io #(.LOCK_CYCLES(16), .CLKDIV(1)) dut (
        .clk(clk), .reset(reset), .outclk(outclk), .locked(locked),
        .wr_hex(wr_hex), .wr_ledr(wr_ledr), .wdata(wdata), .hex_off(hex_off),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .LEDR(LEDR)
    );

    clk_hex_io #(.LOCK_CYCLES(16), .CLKDIV(4)) dut4 (
        .clk(clk), .reset(reset), .outclk(outclk4), .locked(locked4),
        .wr_hex(wr_hex), .wr_ledr(wr_ledr), .wdata(wdata), .hex_off(hex_off),
        .HEX0(d4_h0), .HEX1(d4_h1), .HEX2(d4_h2), .HEX3(d4_h3), .HEX4(d4_h4), .HEX5(d4_h5),
        .LEDR(d4_ledr)
    );

    always #5 clk = ~clk;

    // Expected {HEX5..HEX0}
    localparam logic [41:0] H_FEDEAD = {7'h0E, 7'h06, 7'h21, 7'h06, 7'h08, 7'h21};
    localparam logic [41:0] H_12345  = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
    localparam logic [41:0] H_89ABCD = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [41:0] H_89_OFF = {7'h7F, 7'h10, 7'h08, 7'h03, 7'h46, 7'h7F};
    localparam logic [41:0] H_6789EF = {7'h02, 7'h78, 7'h00, 7'h10, 7'h06, 7'h0E};

    typedef struct {
        string       tag;
        logic [41:0] hex;
        logic [9:0]  ledr;
        logic        lk;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic push(input string tag, input logic [41:0] hex, input logic [9:0] ledr,
                        input logic lk);
        exp_t e;
        e.tag = tag; e.hex = hex; e.ledr = ledr; e.lk = lk;
        sb.push_back(e);
    endtask

    // Monitor: outputs are stable at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, "_hex"}, 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(e.hex));
                check({e.tag, "_ledr"}, 64'(LEDR), 64'(e.ledr));
                check({e.tag, "_locked"}, 64'(locked), 64'(e.lk));
            end
        end
    end

    // Called at a falling edge; drives for one rising edge.
    task automatic write(input string tag, input logic wh, input logic wl, input logic [31:0] d,
                         input logic [41:0] ehex, input logic [9:0] eledr);
        #1;
        wr_hex = wh; wr_ledr = wl; wdata = d;
        @(posedge clk); #1;
        wr_hex = 1'b0; wr_ledr = 1'b0;
        push(tag, ehex, eledr, 1'b1);
        @(negedge clk);
    endtask

    // Called at a falling edge right after reset release.
    task automatic lock_seq(input string tag, input bit chk_div);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            push(tag, H_FEDEAD, 10'h000, (k >= 16));
            if (chk_div) begin
                check("outclk4_phase", 64'(outclk4), 64'((k / 2) % 2));
                if (k == 1) check("outclk_high", 64'(outclk), 64'd1);
            end
            @(negedge clk);
            if (chk_div && k == 1) begin
                #1 check("outclk_low", 64'(outclk), 64'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wr_hex = 1'b1; wr_ledr = 1'b1; wdata = 32'h00123456;
        @(posedge clk); #1;
        push("reset", H_FEDEAD, 10'h000, 1'b0);
        check("outclk_in_reset", 64'(outclk), 64'd0);
        check("outclk4_in_reset", 64'(outclk4), 64'd0);
        @(negedge clk);
        wr_hex = 1'b0; wr_ledr = 1'b0;
        reset = 1'b0;

        lock_seq("lock1", 1'b1);

        write("wr_12345", 1'b1, 1'b0, 32'h00012345, H_12345, 10'h000);
        write("wr_ledr", 1'b0, 1'b1, 32'hFFFFF3A5, H_12345, 10'h3A5);
        write("idle", 1'b0, 1'b0, 32'hFFFFFFFF, H_12345, 10'h3A5);
        write("wr_both", 1'b1, 1'b1, 32'h0089ABCD, H_89ABCD, 10'h3CD);

        #1 hex_off = 6'b100001;
        #1 push("blank", H_89_OFF, 10'h3CD, 1'b1);
        @(negedge clk);
        #1 hex_off = 6'b000000;
        @(negedge clk);

        write("wr_6789ef", 1'b1, 1'b0, 32'h006789EF, H_6789EF, 10'h3CD);

        // Reset mid-lock at count 10
        #1 reset = 1'b1;
        #1 check("async_locked_drop", 64'(locked), 64'd0);
        check("async_hex_reset", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(H_FEDEAD));
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1 check("midlock_locked", 64'(locked), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        lock_seq("lock2", 1'b0);

        // Reset after lock
        #2 reset = 1'b1;
        #1 check("postlock_drop", 64'(locked), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        lock_seq("lock3", 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
